// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle FSM controller for an 8-bit accumulator machine.
// Define CTRL_ILLEGAL_TRAP_EN to trap opcodes 8-15 into HALT with illegal set.
module ctrl_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic [7:0]  out_reg,
    input  logic [7:0]  ACC,
    input  logic [7:0]  out_ula,
    output logic [7:0]  pc,
    output logic        we_reg,
    output logic [3:0]  addr_reg,
    output logic [7:0]  data_reg,
    output logic [7:0]  ula_a,
    output logic [7:0]  ula_b,
    output logic [3:0]  ula_op,
    output logic        halted,
    output logic        illegal
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] READ   = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_MOV = 4'd2;
    localparam logic [3:0] OP_STA = 4'd3;
    localparam logic [3:0] OP_ALU = 4'd4;
    localparam logic [3:0] OP_JMP = 4'd5;
    localparam logic [3:0] OP_JZ  = 4'd6;
    localparam logic [3:0] OP_HLT = 4'd7;

    localparam logic [3:0] ACC_REG  = 4'd0;
    localparam logic [3:0] ZERO_REG = 4'd15;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [7:0]  pc_nx;
    logic [15:0] ir;
    logic [7:0]  opnd;
    logic [7:0]  res;
    logic        halt_set;

    logic [3:0]  opc;
    logic [3:0]  r;
    logic [7:0]  imm;
    logic        acc_zero;

    logic        op_nop;
    logic        op_ldi;
    logic        op_mov;
    logic        op_sta;
    logic        op_alu;
    logic        op_jmp;
    logic        op_jz;
    logic        op_hlt;
    logic        op_ill;

    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;

    assign opc      = ir[15:12];
    assign r        = ir[11:8];
    assign imm      = ir[7:0];
    assign acc_zero = (ACC == 8'h00);

    always_comb begin
        op_nop = (opc == OP_NOP);
        op_ldi = (opc == OP_LDI);
        op_mov = (opc == OP_MOV);
        op_sta = (opc == OP_STA);
        op_alu = (opc == OP_ALU);
        op_jmp = (opc == OP_JMP);
        op_jz  = (opc == OP_JZ);
        op_hlt = (opc == OP_HLT);
        op_ill = opc[3];
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic ill_set;
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        halt_set = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        ill_set  = 1'b0;
`endif
        case (state)
            FETCH: begin
                state_nx = DECODE;
                pc_nx    = pc + 8'd1;
            end
            DECODE: begin
                unique case (1'b1)
                    op_nop: state_nx = FETCH;
                    op_ldi,
                    op_sta: state_nx = WRITE;
                    op_mov,
                    op_alu: state_nx = READ;
                    op_jmp: begin
                        state_nx = FETCH;
                        pc_nx    = imm;
                    end
                    op_jz: begin
                        state_nx = FETCH;
                        if (acc_zero)
                            pc_nx = imm;
                    end
                    op_hlt: begin
                        state_nx = HALT;
                        halt_set = 1'b1;
                    end
                    op_ill: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_nx = HALT;
                        halt_set = 1'b1;
                        ill_set  = 1'b1;
`else
                        state_nx = FETCH;
`endif
                    end
                    default: state_nx = FETCH;
                endcase
            end
            READ:    state_nx = op_alu ? EXEC : WRITE;
            EXEC:    state_nx = WRITE;
            WRITE:   state_nx = FETCH;
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FETCH;
            pc     <= 8'h00;
            ir     <= 16'h0000;
            opnd   <= 8'h00;
            res    <= 8'h00;
            halted <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == FETCH)
                ir <= instr;
            if (state == READ)
                opnd <= out_reg;
            if (state == EXEC)
                res <= out_ula;
            if (halt_set)
                halted <= 1'b1;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            illegal <= 1'b0;
        else if (ill_set)
            illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    // Writes to the hard-wired zero register still occupy the WRITE slot.
    always_comb begin
        we_reg   = 1'b0;
        addr_reg = 4'd0;
        data_reg = 8'h00;
        ula_a    = 8'h00;
        ula_b    = 8'h00;
        ula_op   = 4'd0;
        wr_addr  = 4'd0;
        wr_data  = 8'h00;
        if (rst) begin
            case (state)
                READ: addr_reg = r;
                EXEC: begin
                    ula_a  = ACC;
                    ula_b  = opnd;
                    ula_op = ir[3:0];
                end
                WRITE: begin
                    unique case (1'b1)
                        op_ldi: begin
                            wr_addr = r;
                            wr_data = imm;
                        end
                        op_sta: begin
                            wr_addr = r;
                            wr_data = ACC;
                        end
                        op_mov: begin
                            wr_addr = ACC_REG;
                            wr_data = opnd;
                        end
                        default: begin
                            wr_addr = ACC_REG;
                            wr_data = res;
                        end
                    endcase
                    addr_reg = wr_addr;
                    data_reg = wr_data;
                    we_reg   = (wr_addr != ZERO_REG);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: ROM, register file and ALU models around ctrl_unit,
// with a write scoreboard checked as the controller commits results.
module tb_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr;
    logic [7:0]  out_reg;
    logic [7:0]  ACC;
    logic [7:0]  out_ula;
    logic [7:0]  pc;
    logic        we_reg;
    logic [3:0]  addr_reg;
    logic [7:0]  data_reg;
    logic [7:0]  ula_a;
    logic [7:0]  ula_b;
    logic [3:0]  ula_op;
    logic        halted;
    logic        illegal;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic [15:0] rom [256];
    logic [7:0]  regs [16];
    logic [7:0]  init_regs [16];
    wr_t         sb [$];

    int total = 0;
    int bad = 0;

    ctrl_unit dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .out_reg  (out_reg),
        .ACC      (ACC),
        .out_ula  (out_ula),
        .pc       (pc),
        .we_reg   (we_reg),
        .addr_reg (addr_reg),
        .data_reg (data_reg),
        .ula_a    (ula_a),
        .ula_b    (ula_b),
        .ula_op   (ula_op),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [3:0] op);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign instr   = rom[pc];
    assign out_reg = (addr_reg == 4'hF) ? 8'h00 : regs[addr_reg];
    assign ACC     = regs[0];
    assign out_ula = alu(ula_a, ula_b, ula_op);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= init_regs[i];
        end else if (we_reg) begin
            regs[addr_reg] <= data_reg;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_all;
        for (int i = 0; i < 256; i++)
            rom[i] = 16'h0000;
        for (int i = 0; i < 16; i++)
            init_regs[i] = 8'h00;
        sb.delete();
    endtask

    // Leaves the bench at the sample point of the first FETCH cycle.
    task automatic do_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        clear_all();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (pc !== 8'h00) begin
            bad++;
            $display("FAIL reset_pc: got %h want 00", pc);
        end
        total++;
        if ({we_reg, addr_reg, data_reg} !== 13'h0) begin
            bad++;
            $display("FAIL reset_wport: got we=%b a=%h d=%h want 0",
                     we_reg, addr_reg, data_reg);
        end
        total++;
        if ({ula_a, ula_b, ula_op, halted, illegal} !== 22'h0) begin
            bad++;
            $display("FAIL reset_misc: got a=%h b=%h op=%h h=%b i=%b want 0",
                     ula_a, ula_b, ula_op, halted, illegal);
        end
        rst = 1'b1;
        #1;
        repeat (6) tick();
        total++;
        if (pc !== 8'h03) begin
            bad++;
            $display("FAIL nop_pc: got %h want 03", pc);
        end
    endtask

    task automatic test_ldi;
        wr_t e;
        clear_all();
        rom[0] = 16'h1A05;
        rom[1] = 16'h7000;
        sb.push_back('{a: 4'd10, d: 8'h05});
        do_reset();
        total++;
        if (we_reg !== 1'b0 || pc !== 8'h00) begin
            bad++;
            $display("FAIL ldi_c1: got we=%b pc=%h want 0/00", we_reg, pc);
        end
        tick();
        tick();
        total++;
        if (we_reg !== 1'b1) begin
            bad++;
            $display("FAIL ldi_we: got %b want 1", we_reg);
        end else begin
            e = sb.pop_front();
            if ({addr_reg, data_reg} !== e) begin
                bad++;
                $display("FAIL ldi_wr: got %h/%h want %h/%h",
                         addr_reg, data_reg, e.a, e.d);
            end
        end
        total++;
        if (pc !== 8'h01) begin
            bad++;
            $display("FAIL ldi_pc: got %h want 01", pc);
        end
        repeat (6) tick();
        total++;
        if (halted !== 1'b1 || pc !== 8'h02 || we_reg !== 1'b0) begin
            bad++;
            $display("FAIL hlt_state: got h=%b pc=%h we=%b want 1/02/0",
                     halted, pc, we_reg);
        end
    endtask

    task automatic test_zero_reg;
        clear_all();
        rom[0] = 16'h1F77;
        do_reset();
        total++;
        if (halted !== 1'b0 || pc !== 8'h00) begin
            bad++;
            $display("FAIL zr_reset: got h=%b pc=%h want 0/00", halted, pc);
        end
        tick();
        tick();
        total++;
        if (we_reg !== 1'b0 || addr_reg !== 4'hF || data_reg !== 8'h77) begin
            bad++;
            $display("FAIL zr_write: got we=%b a=%h d=%h want 0/f/77",
                     we_reg, addr_reg, data_reg);
        end
        tick();
        tick();
        total++;
        if (pc !== 8'h02 || we_reg !== 1'b0) begin
            bad++;
            $display("FAIL zr_adv: got pc=%h we=%b want 02/0", pc, we_reg);
        end
    endtask

    task automatic test_alu;
        wr_t e;
        clear_all();
        init_regs[0] = 8'h03;
        init_regs[2] = 8'h04;
        rom[0] = 16'h4201;
        rom[1] = 16'h7000;
        sb.push_back('{a: 4'd0, d: 8'h07});
        do_reset();
        tick();
        tick();
        total++;
        if (addr_reg !== 4'd2 || we_reg !== 1'b0 || ula_op !== 4'd0) begin
            bad++;
            $display("FAIL alu_read: got a=%h we=%b op=%h want 2/0/0",
                     addr_reg, we_reg, ula_op);
        end
        tick();
        total++;
        if (ula_a !== 8'h03 || ula_b !== 8'h04 || ula_op !== 4'd1
            || addr_reg !== 4'd0) begin
            bad++;
            $display("FAIL alu_exec: got a=%h b=%h op=%h ad=%h want 03/04/1/0",
                     ula_a, ula_b, ula_op, addr_reg);
        end
        tick();
        total++;
        if (we_reg !== 1'b1 || ula_a !== 8'h00) begin
            bad++;
            $display("FAIL alu_we: got we=%b ula_a=%h want 1/00", we_reg, ula_a);
        end else begin
            e = sb.pop_front();
            if ({addr_reg, data_reg} !== e) begin
                bad++;
                $display("FAIL alu_wr: got %h/%h want %h/%h",
                         addr_reg, data_reg, e.a, e.d);
            end
        end
        tick();
        total++;
        if (we_reg !== 1'b0 || pc !== 8'h01) begin
            bad++;
            $display("FAIL alu_len: got we=%b pc=%h want 0/01", we_reg, pc);
        end
        tick();
        total++;
        if (pc !== 8'h02) begin
            bad++;
            $display("FAIL alu_next: got pc=%h want 02", pc);
        end
    endtask

    task automatic test_jump;
        clear_all();
        rom[0] = 16'h6040;
        do_reset();
        tick();
        tick();
        total++;
        if (pc !== 8'h40) begin
            bad++;
            $display("FAIL jz_taken: got %h want 40", pc);
        end
        init_regs[0] = 8'h01;
        do_reset();
        tick();
        tick();
        total++;
        if (pc !== 8'h01) begin
            bad++;
            $display("FAIL jz_not: got %h want 01", pc);
        end
        rom[0] = 16'h5080;
        do_reset();
        tick();
        tick();
        total++;
        if (pc !== 8'h80) begin
            bad++;
            $display("FAIL jmp: got %h want 80", pc);
        end
    endtask

    task automatic test_wrap;
        clear_all();
        rom[0] = 16'h50FF;
        do_reset();
        tick();
        tick();
        total++;
        if (pc !== 8'hFF) begin
            bad++;
            $display("FAIL wrap_pre: got %h want ff", pc);
        end
        tick();
        total++;
        if (pc !== 8'h00) begin
            bad++;
            $display("FAIL wrap: got %h want 00", pc);
        end
    endtask

    task automatic test_reset_mid;
        wr_t e;
        clear_all();
        init_regs[0] = 8'h5A;
        rom[0] = 16'h3300;
        sb.push_back('{a: 4'd3, d: 8'h5A});
        do_reset();
        tick();
        tick();
        total++;
        if (we_reg !== 1'b1) begin
            bad++;
            $display("FAIL sta_we: got %b want 1", we_reg);
        end else begin
            e = sb.pop_front();
            if ({addr_reg, data_reg} !== e) begin
                bad++;
                $display("FAIL sta_wr: got %h/%h want %h/%h",
                         addr_reg, data_reg, e.a, e.d);
            end
        end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (we_reg !== 1'b0 || addr_reg !== 4'd0 || data_reg !== 8'h00
            || pc !== 8'h00) begin
            bad++;
            $display("FAIL mid_rst: got we=%b a=%h d=%h pc=%h want 0/0/00/00",
                     we_reg, addr_reg, data_reg, pc);
        end
        rst = 1'b1;
        #1;
        total++;
        if (pc !== 8'h00 || we_reg !== 1'b0) begin
            bad++;
            $display("FAIL mid_rel: got pc=%h we=%b want 00/0", pc, we_reg);
        end
        tick();
        total++;
        if (pc !== 8'h01 || we_reg !== 1'b0) begin
            bad++;
            $display("FAIL mid_fetch: got pc=%h we=%b want 01/0", pc, we_reg);
        end
    endtask

    task automatic test_illegal;
        clear_all();
        rom[0] = 16'h9000;
        do_reset();
        tick();
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        total++;
        if (illegal !== 1'b1 || halted !== 1'b1 || pc !== 8'h01) begin
            bad++;
            $display("FAIL ill_trap: got i=%b h=%b pc=%h want 1/1/01",
                     illegal, halted, pc);
        end
        repeat (4) tick();
        total++;
        if (pc !== 8'h01 || we_reg !== 1'b0) begin
            bad++;
            $display("FAIL ill_frozen: got pc=%h we=%b want 01/0", pc, we_reg);
        end
`else
        total++;
        if (illegal !== 1'b0 || halted !== 1'b0 || pc !== 8'h01) begin
            bad++;
            $display("FAIL ill_nop: got i=%b h=%b pc=%h want 0/0/01",
                     illegal, halted, pc);
        end
        repeat (4) tick();
        total++;
        if (pc !== 8'h03 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL ill_cont: got pc=%h i=%b want 03/0", pc, illegal);
        end
`endif
    endtask

    task automatic test_back_to_back;
        wr_t e;
        bit  done;
        bit  hit15;
        clear_all();
        init_regs[3] = 8'h21;
        rom[0]  = 16'h1105;
        rom[1]  = 16'h1007;
        rom[2]  = 16'h4102;
        rom[3]  = 16'h3400;
        rom[4]  = 16'h2300;
        rom[5]  = 16'h4403;
        rom[6]  = 16'h6009;
        rom[7]  = 16'h10EE;
        rom[8]  = 16'h7000;
        rom[9]  = 16'h1F77;
        rom[10] = 16'h4301;
        rom[11] = 16'h6020;
        rom[12] = 16'h5010;
        rom[16] = 16'h9000;
        rom[17] = 16'h7000;
        sb.push_back('{a: 4'd1, d: 8'h05});
        sb.push_back('{a: 4'd0, d: 8'h07});
        sb.push_back('{a: 4'd0, d: 8'h02});
        sb.push_back('{a: 4'd4, d: 8'h02});
        sb.push_back('{a: 4'd0, d: 8'h21});
        sb.push_back('{a: 4'd0, d: 8'h00});
        sb.push_back('{a: 4'd0, d: 8'h21});
        do_reset();
        done  = 1'b0;
        hit15 = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            if (we_reg === 1'b1) begin
                total++;
                if (addr_reg === 4'hF)
                    hit15 = 1'b1;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL prog_extra: got %h/%h want no write",
                             addr_reg, data_reg);
                end else begin
                    e = sb.pop_front();
                    if ({addr_reg, data_reg} !== e) begin
                        bad++;
                        $display("FAIL prog_wr: got %h/%h want %h/%h",
                                 addr_reg, data_reg, e.a, e.d);
                    end
                end
            end
            if (halted === 1'b1)
                done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL prog_timeout: got halted=%b want 1", halted);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL prog_missing: got %0d left want 0", sb.size());
        end
        total++;
        if (hit15) begin
            bad++;
            $display("FAIL prog_r15: got we on r15 want none");
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        total++;
        if (pc !== 8'h11 || illegal !== 1'b1) begin
            bad++;
            $display("FAIL prog_end: got pc=%h i=%b want 11/1", pc, illegal);
        end
`else
        total++;
        if (pc !== 8'h12 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL prog_end: got pc=%h i=%b want 12/0", pc, illegal);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_zero_reg();
        test_alu();
        test_jump();
        test_wrap();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
